imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the processor's instruction memory. Accepts a framed byte stream on a valid/ready interface, assembles bytes into instruction words, and writes them sequentially into the instruction memory write port. Holds the processor core idle until a complete, valid image has been loaded. Sits between the host/UART byte receiver and `instruction_memory`, opposite the core's instruction fetch (read) side.

## Interface

- `INST_WIDTH`, default `` `INST_WIDTH `` (32): instruction word width; must be a multiple of 8.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (16): instruction memory address width.
- `DEPTH`, default 1024: number of instruction memory words; frames longer than this are rejected.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: single-cycle pulse that arms a new load.
- `rx_valid` input 1: byte present on `rx_data`.
- `rx_data` input 8: stream byte.
- `rx_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: instruction memory write strobe, one cycle per word.
- `imem_addr` output ADDR_WIDTH: word address of the write.
- `imem_wdata` output INST_WIDTH: word to write.
- `cpu_hold` output 1: core must not fetch or retire while high.
- `done` output 1: image loaded successfully.
- `error` output 1: frame rejected.
- `words_loaded` output 16: count of words written in the current frame.

## Operation

- Frame: `LEN_LO`, `LEN_HI` (word count N, little-endian), then N×(INST_WIDTH/8) data bytes, optionally followed by a checksum byte (see Configuration).
- Byte order within a word is little-endian: the first byte goes to `[7:0]`.
- Handshake: a byte is transferred on a cycle with `rx_valid && rx_ready`; no other cycle consumes data.
- States and transitions:
  - IDLE → LEN_LO on `start`.
  - LEN_LO → LEN_HI on handshake.
  - LEN_HI → on handshake: ERR if N > DEPTH; otherwise DATA if N > 0; otherwise CHECK or DONE when N = 0.
  - DATA → CHECK or DONE on the handshake completing word N.
  - CHECK → DONE or ERR on the checksum handshake.
  - DONE and ERR → LEN_LO on `start`.
- `start` is ignored in LEN_LO, LEN_HI, DATA and CHECK.
- On an accepted `start`: clear `done`, `error` and `words_loaded`, reset the byte and word indices, and raise `cpu_hold`.
- `rx_ready` is 1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 otherwise.
- Word assembly uses a shift register and a byte index. The handshake on the last byte of a word:
  - loads `imem_wdata` with the full word;
  - loads `imem_addr` with the word index (starting at 0);
  - sets `imem_we` for exactly the next cycle;
  - increments `words_loaded`.
- Assembly of the next word continues in parallel with that write, so there are no bubbles.
- `cpu_hold` = 1 in every state except DONE. It also stays 1 in ERR, so a bad image never runs.
- `words_loaded` saturates at its maximum and does not wrap.

## Timing

- Reset values:
  - state = IDLE
  - `rx_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0
  - `cpu_hold` = 1, `done` = 0, `error` = 0, `words_loaded` = 0
- `rx_ready` rises the cycle after `start`.
- Write latency: `imem_we` is asserted 1 cycle after the last byte of a word is accepted.
- With the checksum feature off, `done` and `cpu_hold` = 0 are registered 1 cycle after the final data handshake, in the same cycle as the last `imem_we`.
- Back-to-back bytes with `rx_valid` held high sustain 1 byte/cycle.
- Reset mid-frame aborts immediately. Any write already in flight is dropped, and the state returns to IDLE.

## Configuration

- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - A trailing checksum byte follows the data, handled in state CHECK.
  - Running XOR covers all frame bytes, including the length bytes and the checksum byte.
  - Final XOR = 0 → DONE; nonzero → ERR.
- Undefined:
  - The CHECK state and XOR register are not built.
  - The last data word (or LEN_HI when N = 0) transitions directly to DONE.

## Structure

- Shared package / `defines.vh`:
  - State encoding `LOADER_ST_*` (3 bits).
  - `LOADER_LEN_BYTES` = 2.
  - Reuse of `INST_WIDTH` and `ADDR_WIDTH`.
- One sub-module: `byte_word_assembler` (shift register, byte index, word-complete pulse), parameterized by INST_WIDTH.
- FSM, counters and checksum stay in `imem_loader`.

## Test plan

- Nominal load, checksum off: `start`; stream 02 00, 11 22 33 44, AA BB CC DD.
  - `imem_we` twice: addr 0 / 0x44332211, then addr 1 / 0xDDCCBBAA.
  - `done` = 1, `cpu_hold` = 0, `words_loaded` = 2.
- Zero-length frame: 00 00.
  - No `imem_we`; `done` = 1 one cycle after the second byte.
- Oversize frame, DEPTH = 1024: N = 0x0401.
  - `error` = 1, `cpu_hold` = 1, `rx_ready` = 0, no writes.
- Checksum on (`IMEM_LOADER_CHECKSUM_EN`): frame 01 00 01 02 03 04.
  - Checksum 0x05 → `done`.
  - Checksum 0x06 → `error`, while the word is still written to addr 0.
- Backpressure and stall: `rx_valid` toggled randomly.
  - Data and addresses match the nominal case.
  - `start` pulsed mid-DATA is ignored.
- Reset after 3 of 8 data bytes.
  - All outputs return to reset values.
  - A subsequent `start` plus a full frame loads correctly from addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Word/address widths default from the INST_WIDTH / ADDR_WIDTH macros when not already defined.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package imem_loader_pkg;

  typedef enum logic [2:0] {
    LOADER_ST_IDLE   = 3'd0,
    LOADER_ST_LEN_LO = 3'd1,
    LOADER_ST_LEN_HI = 3'd2,
    LOADER_ST_DATA   = 3'd3,
    LOADER_ST_CHECK  = 3'd4,
    LOADER_ST_DONE   = 3'd5,
    LOADER_ST_ERR    = 3'd6
  } loader_state_e;

  localparam int LOADER_LEN_BYTES  = 2;
  localparam int LOADER_INST_WIDTH = `INST_WIDTH;
  localparam int LOADER_ADDR_WIDTH = `ADDR_WIDTH;

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Little-endian byte-to-word assembler: shift register, byte index and a
// combinational word-complete pulse on the byte that finishes a word.
module byte_word_assembler #(
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_in,
  output logic [INST_WIDTH-1:0] word_out,
  output logic                  word_done
);

  localparam int BYTES_PER_WORD = INST_WIDTH / 8;
  localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [INST_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  // New bytes enter at the top so the first byte of a word ends up in [7:0].
  generate
    if (BYTES_PER_WORD == 1) begin : g_single
      assign word_out = byte_in;
    end else begin : g_multi
      assign word_out = {byte_in, shift_q[INST_WIDTH-1:8]};
    end
  endgenerate

  assign word_done = byte_en && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (byte_en) begin
      shift_d = word_out;
      idx_d   = word_done ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed byte stream in, sequential word writes out.
// Optional trailing XOR checksum byte is built when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int INST_WIDTH = LOADER_INST_WIDTH,
  parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_WIDTH-1:0] imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e TAIL_ST = LOADER_ST_CHECK;
`else
  localparam loader_state_e TAIL_ST = LOADER_ST_DONE;
`endif

  loader_state_e         state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [15:0]           words_q, words_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INST_WIDTH-1:0] wdata_q, wdata_d;

  logic                  hs, asm_clear, asm_en, word_done;
  logic [INST_WIDTH-1:0] asm_word;
  logic [15:0]           len_rx;

  assign rx_ready = (state_q == LOADER_ST_LEN_LO) || (state_q == LOADER_ST_LEN_HI) ||
                    (state_q == LOADER_ST_DATA)   || (state_q == LOADER_ST_CHECK);
  assign hs       = rx_valid && rx_ready;
  assign len_rx   = {rx_data, len_lo_q};

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = (state_q != LOADER_ST_DONE);
  assign done         = (state_q == LOADER_ST_DONE);
  assign error        = (state_q == LOADER_ST_ERR);
  assign words_loaded = words_q;

  byte_word_assembler #(
    .INST_WIDTH (INST_WIDTH)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_en   (asm_en),
    .byte_in   (rx_data),
    .word_out  (asm_word),
    .word_done (word_done)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (asm_clear)  csum_d = '0;
    else if (hs)    csum_d = csum_q ^ rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_clear  = 1'b0;
    asm_en     = 1'b0;
    case (state_q)
      LOADER_ST_IDLE, LOADER_ST_DONE, LOADER_ST_ERR: begin
        if (start) begin
          state_d    = LOADER_ST_LEN_LO;
          word_idx_d = '0;
          words_d    = '0;
          asm_clear  = 1'b1;
        end
      end
      LOADER_ST_LEN_LO: begin
        if (hs) begin
          len_lo_d = rx_data;
          state_d  = LOADER_ST_LEN_HI;
        end
      end
      LOADER_ST_LEN_HI: begin
        if (hs) begin
          len_d = len_rx;
          if ({1'b0, len_rx} > DEPTH_L) state_d = LOADER_ST_ERR;
          else if (len_rx != '0)        state_d = LOADER_ST_DATA;
          else                          state_d = TAIL_ST;
        end
      end
      LOADER_ST_DATA: begin
        asm_en = hs;
        if (word_done) begin
          we_d       = 1'b1;
          addr_d     = ADDR_WIDTH'(word_idx_q);
          wdata_d    = asm_word;
          word_idx_d = word_idx_q + 16'd1;
          if (words_q != '1) words_d = words_q + 16'd1;
          if (word_idx_d == len_q) state_d = TAIL_ST;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LOADER_ST_CHECK: begin
        if (hs) state_d = ((csum_q ^ rx_data) == 8'h00) ? LOADER_ST_DONE : LOADER_ST_ERR;
      end
`endif
      default: state_d = LOADER_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOADER_ST_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random frames against a byte-stream reference model.
module tb_imem_loader;

  localparam int W     = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
  localparam int BPW   = W / 8;

  logic          clk = 1'b0;
  logic          reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, imem_we, cpu_hold, done, error;
  logic [AW-1:0] imem_addr;
  logic [W-1:0]  imem_wdata;
  logic [15:0]   words_loaded;

  imem_loader #(
    .INST_WIDTH (W),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  logic [W-1:0] preset[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", imem_we, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", imem_addr, e.addr);
          check("wr_data", imem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values();
    check("rst_rx_ready", rx_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words_loaded", words_loaded, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_rx_ready", rx_ready, 1);
    check("start_done_clr", done, 0);
    check("start_error_clr", error, 0);
    check("start_words_clr", words_loaded, 0);
    check("start_cpu_hold", cpu_hold, 1);
  endtask

  // Called at #1 after a clock edge; returns at #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit stall, input bit with_start);
    int t;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    if (with_start) start = 1'b1;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (rx_ready !== 1'b1) begin
      check("rx_ready_timeout", rx_ready, 1);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit stall, input bit bad_csum, input int start_at);
    logic [7:0]  bytes[$];
    logic [W-1:0] w;
    logic [7:0]  x;
    bit          expect_err;
    int          exp_words;
    pulse_start();
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    expect_err = (n > DEPTH);
    exp_words  = expect_err ? 0 : n;
    if (!expect_err) begin
      for (int i = 0; i < n; i++) begin
        if (preset.size() > 0) w = preset.pop_front();
        else                   w = W'($urandom);
        exp_q.push_back('{addr: AW'(i), data: w});
        for (int k = 0; k < BPW; k++) bytes.push_back(w[8*k +: 8]);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (bytes[i]) x = x ^ bytes[i];
      if (bad_csum) x = x ^ 8'h03;
      bytes.push_back(x);
      expect_err = bad_csum;
`else
      x = 8'h00;
      if (bad_csum) x = 8'h01;
`endif
    end
    foreach (bytes[i]) send_byte(bytes[i], stall, (i == start_at));
    check("end_done", done, !expect_err);
    check("end_error", error, expect_err);
    check("end_cpu_hold", cpu_hold, expect_err);
    check("end_rx_ready", rx_ready, 0);
    check("end_words_loaded", words_loaded, 16'(exp_words));
    repeat (2) @(posedge clk);
    #1;
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;

    preset = '{32'h4433_2211, 32'hDDCC_BBAA};
    run_frame(2, 1'b0, 1'b0, -1);

    run_frame(0, 1'b0, 1'b0, -1);

    run_frame(DEPTH + 1, 1'b0, 1'b0, -1);

    preset = '{32'h0403_0201};
    run_frame(1, 1'b0, 1'b0, -1);
    preset = '{32'h0403_0201};
    run_frame(1, 1'b0, 1'b1, -1);

    preset = '{32'h4433_2211, 32'hDDCC_BBAA};
    run_frame(2, 1'b1, 1'b0, 5);

    // Abort after 3 of 8 data bytes, then reload.
    pulse_start();
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    preset = '{32'h4433_2211, 32'hDDCC_BBAA};
    run_frame(2, 1'b0, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 6);
      run_frame(n, 1'($urandom), 1'($urandom), $urandom_range(0, 2 + n * BPW));
    end

    run_frame(DEPTH, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
